// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch unit.
//   state_t      - fetch FSM state encoding (2 bits)
//   RESET_PC_DEF - default reset PC
//   NOP          - canonical RV nop (addi x0, x0, 0)
//   INST_W       - instruction-bus width
package ifu_pkg;

  localparam int unsigned     INST_W       = 32;
  localparam logic [63:0]     RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/ifu_pcu.sv
// ifu_pcu: program counter register and next-PC selection.
//   clk, rst_n      - clock, asynchronous active-low reset
//   redirect_valid  - load redirect_pc (highest priority)
//   redirect_pc     - redirect target
//   advance         - step to pc+4 (instruction delivered)
//   pc              - current PC
module ifu_pcu
  import ifu_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF[PC_W-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  // pc+4 wraps modulo 2^PC_W with no overflow indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit. Owns the PC, issues one instruction-memory
// read at a time and hands each instruction plus its PC to decode over a
// valid/ready handshake. Accepts single-cycle PC redirects.
//   clk_i, rst_n_i                       - clock, async active-low reset
//   imem_req_valid_o/ready_i, imem_addr_o - fetch request
//   imem_rsp_valid_i, imem_rdata_i        - fetch response
//   f_valid_o/f_ready_i, inst_o, pc_o     - decoder handshake
//   misalign_o                            - inst_o is a misaligned-fetch nop
//   redirect_valid_i, redirect_pc_i       - PC redirect
// Optional feature macro: YSYX_23060251_IFU_MISALIGN_EN
//   defined   - misaligned PCs skip memory and present a nop with misalign_o=1
//   undefined - misalign_o=0, fetch address is the PC with bits [1:0] cleared
module ifu
  import ifu_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF[PC_W-1:0]
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            f_valid_o,
  input  logic            f_ready_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] pc_o,
  output logic            misalign_o,
  input  logic            redirect_valid_i,
  input  logic [PC_W-1:0] redirect_pc_i
);

  state_t          state;
  logic            kill;
  logic [PC_W-1:0] pc;
  logic            aligned;
  logic            advance;
  logic            req_hs;

  ifu_pcu #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pcu (
    .clk            (clk_i),
    .rst_n          (rst_n_i),
    .redirect_valid (redirect_valid_i),
    .redirect_pc    (redirect_pc_i),
    .advance        (advance),
    .pc             (pc)
  );

`ifdef YSYX_23060251_IFU_MISALIGN_EN
  logic misalign_q;
  assign aligned     = (pc[1:0] == 2'b00);
  assign imem_addr_o = pc;
  assign misalign_o  = misalign_q;
`else
  assign aligned     = 1'b1;
  assign imem_addr_o = {pc[PC_W-1:2], 2'b00};
  assign misalign_o  = 1'b0;
`endif

  // Request valid is decoded from registered state and PC only, so no
  // input reaches it combinationally.
  assign imem_req_valid_o = (state == REQ) && aligned;
  assign req_hs           = imem_req_valid_o && imem_req_ready_i;
  assign advance          = (state == HOLD) && f_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      kill      <= 1'b0;
      f_valid_o <= 1'b0;
      inst_o    <= '0;
      pc_o      <= RESET_PC;
`ifdef YSYX_23060251_IFU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: state <= REQ;

        REQ: begin
          // A redirect without a handshake just retargets the request
          // (the PC register takes the new address).
          if (req_hs) begin
            state <= WAIT;
            kill  <= redirect_valid_i;
          end
`ifdef YSYX_23060251_IFU_MISALIGN_EN
          else if (!aligned && !redirect_valid_i) begin
            state      <= HOLD;
            f_valid_o  <= 1'b1;
            inst_o     <= NOP;
            pc_o       <= pc;
            misalign_q <= 1'b1;
          end
`endif
        end

        WAIT: begin
          if (imem_rsp_valid_i) begin
            // A redirect in the response cycle drops that response directly.
            if (kill || redirect_valid_i) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              state     <= HOLD;
              f_valid_o <= 1'b1;
              inst_o    <= imem_rdata_i;
              pc_o      <= pc;
            end
          end else if (redirect_valid_i) begin
            kill <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_valid_i || f_ready_i) begin
            state     <= REQ;
            f_valid_o <= 1'b0;
`ifdef YSYX_23060251_IFU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] addr;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] inst;
  logic [63:0] pc_out;
  logic        misalign;
  logic        redir;
  logic [63:0] redir_pc;

  int unsigned tests = 0;
  int unsigned fails = 0;

  int unsigned mem_lat;
  int unsigned hs_count = 0;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  ifu #(
    .PC_W     (64),
    .RESET_PC (RST_PC)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_addr_o      (addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rdata_i     (rdata),
    .f_valid_o        (f_valid),
    .f_ready_i        (f_ready),
    .inst_o           (inst),
    .pc_o             (pc_out),
    .misalign_o       (misalign),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h0000_0513;
    return a[31:0] ^ 32'h1357_2468;
  endfunction

  // Memory: always ready, one outstanding read, response mem_lat cycles
  // after acceptance. Drives its inputs just after the falling edge.
  initial begin : mem_model
    logic        pend;
    int unsigned cnt;
    logic [63:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    rsp_valid = 1'b0; rdata = '0; req_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            rsp_valid = 1'b1;
            rdata     = mem_data(paddr);
            pend      = 1'b0;
          end
        end
        if (req_valid && req_ready) begin
          pend  = 1'b1;
          cnt   = mem_lat;
          paddr = addr;
          hs_count++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_fvalid(input int unsigned max, output int unsigned n);
    n = 0;
    while (!f_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_f_valid",   64'(f_valid),   64'h0);
    chk("rst_req_valid", 64'(req_valid), 64'h0);
    chk("rst_misalign",  64'(misalign),  64'h0);
    chk("rst_inst",      64'(inst),      64'h0);
    chk("rst_pc_o",      pc_out,         RST_PC);
    chk("rst_addr",      addr,           RST_PC);
  endtask

  typedef struct {
    int unsigned lat;
    int unsigned stall;
    logic [63:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int unsigned n;
    int unsigned hs_before;

    vecs[0] = '{lat: 1, stall: 5, pc: 64'h0000_0000_8000_0000, inst: 32'h0000_0513};
    vecs[1] = '{lat: 1, stall: 0, pc: 64'h0000_0000_8000_0004, inst: 32'h9357_246C};
    vecs[2] = '{lat: 3, stall: 2, pc: 64'h0000_0000_8000_0008, inst: 32'h9357_2460};
    vecs[3] = '{lat: 2, stall: 0, pc: 64'h0000_0000_8000_000C, inst: 32'h9357_2464};

    rst_n = 1'b0; f_ready = 1'b0; redir = 1'b0; redir_pc = '0;
    mem_lat = vecs[0].lat;
    repeat (2) tick();
    chk_reset_vals();

    rst_n = 1'b1;                          // cycle 0: IDLE
    chk("idle_no_req", 64'(req_valid), 64'h0);
    tick();                                // cycle 1: first request

    // Steady fetch with decoder stalls and varying memory latency.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("v%0d_req_valid", i), 64'(req_valid), 64'h1);
      chk($sformatf("v%0d_req_addr", i), addr, vecs[i].pc);
      wait_fvalid(20, n);
      chk($sformatf("v%0d_latency", i), 64'(n), 64'(vecs[i].lat + 1));
      chk($sformatf("v%0d_pc_o", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d_inst", i), 64'(inst), 64'(vecs[i].inst));
      for (int s = 0; s < int'(vecs[i].stall); s++) begin
        tick();
        chk($sformatf("v%0d_stall_fv", i), 64'(f_valid), 64'h1);
        chk($sformatf("v%0d_stall_pc", i), pc_out, vecs[i].pc);
        chk($sformatf("v%0d_stall_inst", i), 64'(inst), 64'(vecs[i].inst));
        chk($sformatf("v%0d_stall_noreq", i), 64'(req_valid), 64'h0);
      end
      f_ready = 1'b1;
      mem_lat = (i < 3) ? vecs[i+1].lat : 3;
      tick();
      f_ready = 1'b0;
    end

    // Redirect while waiting on a slow response: stale data is dropped.
    chk("b_req_addr", addr, 64'h0000_0000_8000_0010);
    tick();                                // WAIT
    redir = 1'b1; redir_pc = 64'h0000_0000_8000_1000; mem_lat = 1;
    tick();
    redir = 1'b0;
    n = 0;
    while (!req_valid && n < 10) begin
      chk("b_drop_fvalid", 64'(f_valid), 64'h0);
      tick();
      n++;
    end
    chk("b_drain_cycles", 64'(n), 64'h2);
    chk("b_fvalid_low", 64'(f_valid), 64'h0);
    chk("b_redir_addr", addr, 64'h0000_0000_8000_1000);
    wait_fvalid(20, n);
    chk("b_latency", 64'(n), 64'h2);
    chk("b_pc_o", pc_out, 64'h0000_0000_8000_1000);
    chk("b_inst", 64'(inst), 64'h9357_3468);

    // Redirect coincident with a HOLD handshake.
    f_ready = 1'b1; redir = 1'b1; redir_pc = 64'h0000_0000_8000_0200;
    tick();
    f_ready = 1'b0; redir = 1'b0;
    chk("c_fvalid_low", 64'(f_valid), 64'h0);
    chk("c_req_valid", 64'(req_valid), 64'h1);
    chk("c_redir_addr", addr, 64'h0000_0000_8000_0200);
    wait_fvalid(20, n);
    chk("c_latency", 64'(n), 64'h2);
    chk("c_pc_o", pc_out, 64'h0000_0000_8000_0200);
    chk("c_inst", 64'(inst), 64'h9357_2668);

    // PC wrap at the top of the address space.
    f_ready = 1'b1; redir = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    f_ready = 1'b0; redir = 1'b0;
    chk("d_top_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_fvalid(20, n);
    chk("d_top_pc_o", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("d_top_inst", 64'(inst), 64'hECA8_DB94);
    f_ready = 1'b1; mem_lat = 3;
    tick();
    f_ready = 1'b0;
    chk("d_wrap_req", 64'(req_valid), 64'h1);
    chk("d_wrap_addr", addr, 64'h0);

    // Reset in the middle of an outstanding read.
    tick();                                // WAIT
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    mem_lat = 1;
    tick();
    rst_n = 1'b1;                          // cycle 0
    tick();                                // cycle 1
    chk("e_req_valid", 64'(req_valid), 64'h1);
    chk("e_req_addr", addr, RST_PC);
    wait_fvalid(20, n);
    chk("e_latency", 64'(n), 64'h2);
    chk("e_inst", 64'(inst), 64'h0000_0513);
    chk("e_pc_o", pc_out, RST_PC);

    // Misaligned redirect target.
    hs_before = hs_count;
    f_ready = 1'b1; redir = 1'b1; redir_pc = 64'h0000_0000_8000_0002;
    tick();
    f_ready = 1'b0; redir = 1'b0;
`ifdef YSYX_23060251_IFU_MISALIGN_EN
    chk("f_no_req", 64'(req_valid), 64'h0);
    tick();
    chk("f_fvalid", 64'(f_valid), 64'h1);
    chk("f_inst_nop", 64'(inst), 64'h0000_0013);
    chk("f_misalign", 64'(misalign), 64'h1);
    chk("f_pc_o", pc_out, 64'h0000_0000_8000_0002);
    chk("f_no_handshake", 64'(hs_count), 64'(hs_before));
`else
    chk("f_req_valid", 64'(req_valid), 64'h1);
    chk("f_masked_addr", addr, 64'h0000_0000_8000_0000);
    wait_fvalid(20, n);
    chk("f_latency", 64'(n), 64'h2);
    chk("f_pc_o", pc_out, 64'h0000_0000_8000_0002);
    chk("f_inst", 64'(inst), 64'h0000_0513);
    chk("f_misalign", 64'(misalign), 64'h0);
    chk("f_one_handshake", 64'(hs_count), 64'(hs_before + 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
